program_loader: RTL

Boot-time loader upstream of the processor core. It receives a framed program image as a byte stream, assembles big-endian 32-bit words, writes them into the shared program/data RAM from address 0, and verifies an XOR checksum. It holds the processor in reset for the whole load and releases it only after a valid image. The top level muxes RAM address, data and set onto the loader while `o_cpu_reset` is high.

---
 rtl/processor_pkg.sv | 25 ++
 rtl/program_loader_if.sv | 30 +++
 rtl/program_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared processor definitions: bus widths, opcode constants and the boot loader state encoding.
// No logic lives here; the loader and its interface import it.
package processor_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h58;
    localparam logic [7:0] OP_STORE = 8'h59;
    localparam logic [7:0] OP_JUMP  = 8'h60;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_HI,
        LD_LEN_LO,
        LD_DATA,
        LD_WRITE,
        LD_CHECK,
        LD_DONE,
        LD_ERROR
    } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, RAM write port and status of the boot loader.
// The master modport is the stream source / system side, slave is the loader.
interface program_loader_if;
    import processor_pkg::*;

    logic              i_start;
    logic [7:0]        i_byte;
    logic              i_byte_valid;
    logic              o_byte_ready;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_data;
    logic              o_ram_set;
    logic              o_cpu_reset;
    logic              o_busy;
    logic              o_done;
    logic              o_error;

    modport master (
        output i_start, i_byte, i_byte_valid,
        input  o_byte_ready, o_ram_addr, o_ram_data, o_ram_set,
        input  o_cpu_reset, o_busy, o_done, o_error
    );

    modport slave (
        input  i_start, i_byte, i_byte_valid,
        output o_byte_ready, o_ram_addr, o_ram_data, o_ram_set,
        output o_cpu_reset, o_busy, o_done, o_error
    );

endinterface

// File: rtl/program_loader.sv
// Boot loader: length-framed big-endian byte stream -> 32-bit RAM writes from address 0, XOR-checked.
// One WRITE cycle after every 4th byte (4 bytes / 5 cycles peak); bytes are held by the source while ready is low.
module program_loader
    import processor_pkg::*;
#(
    parameter int RAM_WORDS = 65536
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    program_loader_if.slave ld
);

    loader_state_e     state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [15:0]       len_q, len_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              ram_set_q, ram_set_d;
    logic              byte_ready_q, cpu_reset_q, busy_q, done_q, error_q;
    logic              xfer;
    logic [15:0]       len_rx;

    // Ready is a pure state decode, so a transfer never depends combinationally on valid->ready.
    assign xfer   = ld.i_byte_valid && byte_ready_q;
    assign len_rx = {len_q[15:8], ld.i_byte};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_set_d  = 1'b0;

        case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (ld.i_start) begin
                    state_d    = LD_LEN_HI;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    csum_d     = '0;
                end
            end
            LD_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = ld.i_byte;
                    state_d     = LD_LEN_LO;
                end
            end
            LD_LEN_LO: begin
                if (xfer) begin
                    len_d = len_rx;
                    if ({16'd0, len_rx} > 32'(RAM_WORDS)) begin
                        state_d = LD_ERROR;
                    end else if (len_rx == 16'd0) begin
                        state_d = LD_CHECK;
                    end else begin
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (xfer) begin
                    shift_d    = {shift_q[15:0], ld.i_byte};
                    csum_d     = csum_q ^ ld.i_byte;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = LD_WRITE;
                        ram_set_d  = 1'b1;
                        ram_addr_d = word_cnt_q;
                        ram_data_d = {shift_q, ld.i_byte};
                    end
                end
            end
            LD_WRITE: begin
                word_cnt_d = word_cnt_q + 16'd1;
                if (({1'b0, word_cnt_q} + 17'd1) == {1'b0, len_q}) begin
                    state_d = LD_CHECK;
                end else begin
                    state_d = LD_DATA;
                end
            end
            LD_CHECK: begin
                if (xfer) begin
                    state_d = (ld.i_byte == csum_q) ? LD_DONE : LD_ERROR;
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= LD_IDLE;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            len_q        <= '0;
            shift_q      <= '0;
            csum_q       <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            ram_set_q    <= 1'b0;
            byte_ready_q <= 1'b0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            len_q        <= len_d;
            shift_q      <= shift_d;
            csum_q       <= csum_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            ram_set_q    <= ram_set_d;
            byte_ready_q <= (state_d == LD_LEN_HI) || (state_d == LD_LEN_LO) ||
                            (state_d == LD_DATA)   || (state_d == LD_CHECK);
            cpu_reset_q  <= (state_d != LD_DONE);
            busy_q       <= (state_d == LD_LEN_HI) || (state_d == LD_LEN_LO) ||
                            (state_d == LD_DATA)   || (state_d == LD_WRITE)  ||
                            (state_d == LD_CHECK);
            done_q       <= (state_d == LD_DONE);
            error_q      <= (state_d == LD_ERROR);
        end
    end

    assign ld.o_byte_ready = byte_ready_q;
    assign ld.o_ram_addr   = ram_addr_q;
    assign ld.o_ram_data   = ram_data_q;
    assign ld.o_ram_set    = ram_set_q;
    assign ld.o_cpu_reset  = cpu_reset_q;
    assign ld.o_busy       = busy_q;
    assign ld.o_done       = done_q;
    assign ld.o_error      = error_q;

endmodule
